// File: rtl/mbox_tx_arb.sv
// mbox_tx_arb: packet-level round-robin arbiter sharing one mailbox write channel among NREQ requesters
//
// Ports:
//   aclk, resetn                        clock, asynchronous active-low reset
//   req_w_dat/valid/done/abort (in)     per-requester write data, valid, end-of-packet, local abort
//   req_w_ready, req_r_abort (out)      per-requester ready, remote/timeout abort notification
//   mbox_w_dat/valid/done/abort (out)   mailbox write channel and abort request/ack pulse
//   mbox_w_ready, mbox_r_abort (in)     mailbox ready and abort request/ack
//   grant_id, busy, timeout_irq (out)   current/last grant, not-idle flag, stall timeout pulse
// Optional feature: define MBOX_ARB_TIMEOUT_EN to abort a granted packet that stalls TIMEOUT_CYCLES cycles.
module mbox_tx_arb #(
  parameter int NREQ           = 4,
  parameter int IDW            = $clog2(NREQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic [NREQ*32-1:0] req_w_dat,
  input  logic [NREQ-1:0]   req_w_valid,
  output logic [NREQ-1:0]   req_w_ready,
  input  logic [NREQ-1:0]   req_w_done,
  input  logic [NREQ-1:0]   req_w_abort,
  output logic [NREQ-1:0]   req_r_abort,
  output logic [31:0]       mbox_w_dat,
  output logic              mbox_w_valid,
  input  logic              mbox_w_ready,
  output logic              mbox_w_done,
  output logic              mbox_w_abort,
  input  logic              mbox_r_abort,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              timeout_irq
);
  typedef enum logic [1:0] {IDLE, GRANT, ABORT} state_e;
  state_e          state_q;
  logic [IDW-1:0]  grant_q, last_q, pick, idx;
  logic [NREQ-1:0] r_abort_q;
  logic            w_abort_q, g_on, tmo, kill;
  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("mbox_tx_arb: unsupported parameter set");
  end
  // Scan downward in priority so the requester closest after last_q wins.
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int i = NREQ; i > 0; i--) begin
      idx = IDW'((int'(last_q) + i) % NREQ);
      if (req_w_valid[idx]) pick = idx;
    end
  end
  assign g_on = state_q == GRANT;
  // Any abort source ends the packet, so a coincident done must not reach the mailbox.
  assign kill = mbox_r_abort | req_w_abort[grant_q] | tmo;
  always_comb begin
    req_w_ready          = '0;
    req_w_ready[grant_q] = g_on & mbox_w_ready;
  end
  assign mbox_w_dat   = g_on ? req_w_dat[{grant_q, 5'd0} +: 32] : '0;
  assign mbox_w_valid = g_on & req_w_valid[grant_q];
  assign mbox_w_done  = g_on & req_w_done[grant_q] & ~kill;
  assign mbox_w_abort = w_abort_q;
  assign req_r_abort  = r_abort_q;
  assign grant_id     = grant_q;
  assign busy         = state_q != IDLE;
`ifdef MBOX_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        irq_q, beat;
  assign beat        = mbox_w_valid & mbox_w_ready;
  assign tmo         = g_on & ~beat & (cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_irq = irq_q;
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= (g_on & ~beat) ? cnt_q + 32'd1 : '0;
      irq_q <= tmo & ~mbox_r_abort;
    end
  end
`else
  assign tmo         = 1'b0;
  assign timeout_irq = 1'b0;
`endif
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDW'(NREQ - 1);
      w_abort_q <= 1'b0;
      r_abort_q <= '0;
    end else begin
      w_abort_q <= 1'b0;
      r_abort_q <= '0;
      case (state_q)
        IDLE: begin
          w_abort_q <= mbox_r_abort;
          if (|req_w_valid) begin
            grant_q <= pick;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          w_abort_q <= kill;
          // Remote abort wins over local abort/timeout and skips ABORT entirely.
          if (mbox_r_abort) begin
            r_abort_q[grant_q] <= 1'b1;
            state_q            <= IDLE;
            last_q             <= grant_q;
          end else if (req_w_abort[grant_q] | tmo) begin
            r_abort_q[grant_q] <= tmo;
            state_q            <= ABORT;
          end else if (req_w_done[grant_q]) begin
            state_q <= IDLE;
            last_q  <= grant_q;
          end
        end
        ABORT: if (mbox_r_abort) begin
          state_q <= IDLE;
          last_q  <= grant_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mbox_tx_arb.sv
// tb_mbox_tx_arb: scoreboard bench for the mailbox write arbiter
module tb_mbox_tx_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  logic              aclk = 1'b0;
  logic              resetn;
  logic [NREQ*32-1:0] req_w_dat;
  logic [NREQ-1:0]   req_w_valid, req_w_ready, req_w_done, req_w_abort, req_r_abort;
  logic [31:0]       mbox_w_dat;
  logic              mbox_w_valid, mbox_w_ready, mbox_w_done, mbox_w_abort, mbox_r_abort;
  logic [IDW-1:0]    grant_id;
  logic              busy, timeout_irq;
  typedef struct {int id; logic [31:0] dat;} exp_t;
  exp_t sb[$];
  int   glog[$];
  int   vec = 0, bad = 0, done_cnt = 0, exp_done = 0, open_id = 0, hit;
  bit   open = 0;
  mbox_tx_arb #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .resetn(resetn),
    .req_w_dat(req_w_dat), .req_w_valid(req_w_valid), .req_w_ready(req_w_ready),
    .req_w_done(req_w_done), .req_w_abort(req_w_abort), .req_r_abort(req_r_abort),
    .mbox_w_dat(mbox_w_dat), .mbox_w_valid(mbox_w_valid), .mbox_w_ready(mbox_w_ready),
    .mbox_w_done(mbox_w_done), .mbox_w_abort(mbox_w_abort), .mbox_r_abort(mbox_r_abort),
    .grant_id(grant_id), .busy(busy), .timeout_irq(timeout_irq)
  );
  always #5 aclk = ~aclk;
  // Beats leave the mailbox port at the next rising edge; match each against the oldest queued beat of the granted requester.
  always @(negedge aclk) if (resetn) begin
    if (!busy) open = 0;
    if (mbox_w_valid && mbox_w_ready) begin
      hit = -1;
      foreach (sb[i]) if (hit < 0 && sb[i].id == int'(grant_id)) hit = i;
      vec++;
      if (hit < 0) begin
        bad++;
        $display("FAIL beat_unexpected: got beat id %0d dat %h, required no beat", grant_id, mbox_w_dat);
      end else begin
        if (mbox_w_dat !== sb[hit].dat) begin
          bad++;
          $display("FAIL beat_data: got %h, required %h", mbox_w_dat, sb[hit].dat);
        end
        sb.delete(hit);
      end
      vec++;
      if (req_w_ready !== (NREQ'(1) << grant_id)) begin
        bad++;
        $display("FAIL ready_onehot: got %b, required %b", req_w_ready, NREQ'(1) << grant_id);
      end
      vec++;
      if (open && open_id != int'(grant_id)) begin
        bad++;
        $display("FAIL interleave: got beat from %0d, required %0d", grant_id, open_id);
      end
      if (!open) begin
        glog.push_back(int'(grant_id));
        open    = 1;
        open_id = int'(grant_id);
      end
    end
    if (mbox_w_done) begin
      done_cnt++;
      open = 0;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic apply_reset();
    resetn       = 1'b0;
    req_w_dat    = '0;
    req_w_valid  = '0;
    req_w_done   = '0;
    req_w_abort  = '0;
    mbox_r_abort = 1'b0;
    mbox_w_ready = 1'b1;
    open         = 0;
    repeat (2) @(posedge aclk);
    #1 resetn = 1'b1;
  endtask
  task automatic drive_beats(input int id, input int n, input int seq0);
    for (int k = 0; k < n; k++) begin
      logic [31:0] d;
      bit          acc;
      int          w;
      d = {8'(id), 24'(seq0 + k)};
      req_w_dat[id*32 +: 32] = d;
      req_w_valid[id]        = 1'b1;
      sb.push_back('{id: id, dat: d});
      acc = 0;
      w   = 0;
      while (!acc && w < 200) begin
        @(negedge aclk);
        acc = req_w_ready[id];
        tick();
        w++;
      end
      vec++;
      if (!acc) begin
        bad++;
        $display("FAIL beat_accept: req %0d beat %0d got no ready in %0d cycles, required ready", id, k, w);
      end
    end
    req_w_valid[id] = 1'b0;
  endtask
  task automatic send_pkt(input int id, input int n, input int seq0);
    drive_beats(id, n, seq0);
    req_w_done[id] = 1'b1;
    exp_done++;
    tick();
    req_w_done[id] = 1'b0;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    #1;
    vec++;
    if (busy !== 1'b0 || mbox_w_valid !== 1'b0 || req_w_ready !== '0) begin
      bad++;
      $display("FAIL reset_held: got busy %b valid %b ready %b, required 0 0 0", busy, mbox_w_valid, req_w_ready);
    end
    apply_reset();
    @(negedge aclk);
    vec++;
    if ({busy, grant_id, req_w_ready, req_r_abort, mbox_w_valid, mbox_w_done, mbox_w_abort, timeout_irq} !== '0 || mbox_w_dat !== '0) begin
      bad++;
      $display("FAIL reset_state: got busy %b grant %0d ready %b r_abort %b valid %b done %b abort %b irq %b dat %h, required all 0",
               busy, grant_id, req_w_ready, req_r_abort, mbox_w_valid, mbox_w_done, mbox_w_abort, timeout_irq, mbox_w_dat);
    end
  endtask
  task automatic test_single();
    int d0 = done_cnt;
    glog.delete();
    tick();
    fork
      send_pkt(1, 3, 'h10);
      begin
        @(negedge aclk);
        vec++;
        if (busy !== 1'b0 || mbox_w_valid !== 1'b0 || req_w_ready !== '0) begin
          bad++;
          $display("FAIL arb_latency: got busy %b valid %b ready %b, required 0 0 0", busy, mbox_w_valid, req_w_ready);
        end
        @(negedge aclk);
        vec++;
        if (busy !== 1'b1 || grant_id !== 2'd1 || mbox_w_valid !== 1'b1) begin
          bad++;
          $display("FAIL grant_single: got busy %b grant %0d valid %b, required 1 1 1", busy, grant_id, mbox_w_valid);
        end
      end
    join
    tick();
    @(negedge aclk);
    vec++;
    if (busy !== 1'b0 || grant_id !== 2'd1 || done_cnt - d0 != 1 || glog.size() != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL single_pkt: got busy %b grant %0d dones %0d packets %0d left %0d, required 0 1 1 1 0",
               busy, grant_id, done_cnt - d0, glog.size(), sb.size());
    end
  endtask
  task automatic test_two();
    bit stop = 0;
    int d0;
    apply_reset();
    d0 = done_cnt;
    glog.delete();
    tick();
    fork
      begin
        fork
          send_pkt(0, 4, 'h20);
          send_pkt(2, 3, 'h28);
        join
        stop = 1;
      end
      while (!stop) begin
        mbox_w_ready = 1'($urandom_range(0, 1));
        tick();
      end
    join
    mbox_w_ready = 1'b1;
    tick();
    @(negedge aclk);
    vec++;
    if (glog.size() != 2 || glog[0] != 0 || glog[1] != 2 || done_cnt - d0 != 2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rr_order: got %0d packets first %0d second %0d dones %0d busy %b, required 2 packets 0 then 2, 2 dones, busy 0",
               glog.size(), glog.size() > 0 ? glog[0] : -1, glog.size() > 1 ? glog[1] : -1, done_cnt - d0, busy);
    end
  endtask
  task automatic test_wrap();
    glog.delete();
    tick();
    fork
      begin
        send_pkt(3, 4, 'h30);
        send_pkt(3, 2, 'h38);
      end
      begin
        int w = 0;
        while (!(busy && grant_id == 2'd3) && w < 50) begin
          @(negedge aclk);
          w++;
        end
        vec++;
        if (w >= 50) begin
          bad++;
          $display("FAIL wrap_wait: got no grant to 3 in %0d cycles, required grant", w);
        end
        tick();
        send_pkt(1, 2, 'h40);
      end
    join
    tick();
    @(negedge aclk);
    vec++;
    if (glog.size() != 3 || glog[0] != 3 || glog[1] != 1 || glog[2] != 3) begin
      bad++;
      $display("FAIL rr_wrap: got %0d packets order %0d %0d %0d, required 3 1 3", glog.size(),
               glog.size() > 0 ? glog[0] : -1, glog.size() > 1 ? glog[1] : -1, glog.size() > 2 ? glog[2] : -1);
    end
  endtask
  task automatic test_local_abort();
    tick();
    drive_beats(2, 2, 'h50);
    req_w_abort[2] = 1'b1;
    tick();
    req_w_abort[2] = 1'b0;
    @(negedge aclk);
    vec++;
    if (mbox_w_abort !== 1'b1 || busy !== 1'b1 || mbox_w_valid !== 1'b0) begin
      bad++;
      $display("FAIL local_abort_pulse: got abort %b busy %b valid %b, required 1 1 0", mbox_w_abort, busy, mbox_w_valid);
    end
    tick();
    req_w_valid[2] = 1'b1;
    req_w_done[2]  = 1'b1;
    @(negedge aclk);
    vec++;
    if (mbox_w_abort !== 1'b0 || busy !== 1'b1 || mbox_w_valid !== 1'b0 || req_w_ready !== '0 || mbox_w_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_hold: got abort %b busy %b valid %b ready %b done %b, required 0 1 0 0 0",
               mbox_w_abort, busy, mbox_w_valid, req_w_ready, mbox_w_done);
    end
    tick();
    req_w_valid[2] = 1'b0;
    req_w_done[2]  = 1'b0;
    mbox_r_abort   = 1'b1;
    tick();
    mbox_r_abort = 1'b0;
    @(negedge aclk);
    vec++;
    if (busy !== 1'b0 || mbox_w_abort !== 1'b0 || req_r_abort !== '0) begin
      bad++;
      $display("FAIL abort_exit: got busy %b abort %b r_abort %b, required 0 0 0", busy, mbox_w_abort, req_r_abort);
    end
  endtask
  task automatic test_remote_abort();
    int d0;
    tick();
    drive_beats(0, 2, 'h60);
    mbox_r_abort = 1'b1;
    tick();
    mbox_r_abort = 1'b0;
    @(negedge aclk);
    vec++;
    if (req_r_abort !== 4'b0001 || mbox_w_abort !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL remote_abort: got r_abort %b abort %b busy %b, required 0001 1 0", req_r_abort, mbox_w_abort, busy);
    end
    tick();
    d0            = done_cnt;
    req_w_done[0] = 1'b1;
    @(negedge aclk);
    vec++;
    if (req_r_abort !== '0 || mbox_w_abort !== 1'b0 || mbox_w_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL late_done: got r_abort %b abort %b done %b busy %b, required 0000 0 0 0", req_r_abort, mbox_w_abort, mbox_w_done, busy);
    end
    tick();
    req_w_done[0] = 1'b0;
    mbox_r_abort  = 1'b1;
    tick();
    mbox_r_abort = 1'b0;
    @(negedge aclk);
    vec++;
    if (mbox_w_abort !== 1'b1 || req_r_abort !== '0 || busy !== 1'b0 || done_cnt != d0) begin
      bad++;
      $display("FAIL idle_ack: got abort %b r_abort %b busy %b dones %0d, required 1 0000 0 0", mbox_w_abort, req_r_abort, busy, done_cnt - d0);
    end
  endtask
  task automatic test_collisions();
    tick();
    drive_beats(3, 1, 'h70);
    req_w_done[3]  = 1'b1;
    req_w_abort[3] = 1'b1;
    @(negedge aclk);
    vec++;
    if (mbox_w_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_beats_done: got done %b, required 0", mbox_w_done);
    end
    tick();
    req_w_done[3]  = 1'b0;
    req_w_abort[3] = 1'b0;
    @(negedge aclk);
    vec++;
    if (busy !== 1'b1 || mbox_w_abort !== 1'b1) begin
      bad++;
      $display("FAIL abort_state: got busy %b abort %b, required 1 1", busy, mbox_w_abort);
    end
    tick();
    mbox_r_abort = 1'b1;
    tick();
    mbox_r_abort = 1'b0;
    drive_beats(2, 1, 'h78);
    req_w_abort[2] = 1'b1;
    mbox_r_abort   = 1'b1;
    tick();
    req_w_abort[2] = 1'b0;
    mbox_r_abort   = 1'b0;
    @(negedge aclk);
    vec++;
    if (busy !== 1'b0 || req_r_abort !== 4'b0100 || mbox_w_abort !== 1'b1) begin
      bad++;
      $display("FAIL remote_wins: got busy %b r_abort %b abort %b, required 0 0100 1", busy, req_r_abort, mbox_w_abort);
    end
  endtask
  task automatic test_stall();
    int cnt = 0, first = -1, exp_cnt = 0, exp_first = -1;
    logic [NREQ-1:0] ra = '0;
`ifdef MBOX_ARB_TIMEOUT_EN
    exp_cnt   = 1;
    exp_first = 16;
`endif
    tick();
    req_w_valid[1] = 1'b1;
    tick();
    req_w_valid[1] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge aclk);
      if (timeout_irq) begin
        cnt++;
        if (first < 0) begin
          first = n;
          ra    = req_r_abort;
        end
      end
    end
    vec++;
    if (cnt != exp_cnt || first != exp_first || busy !== 1'b1) begin
      bad++;
      $display("FAIL stall_timeout: got %0d irq pulses first at %0d busy %b, required %0d at %0d busy 1", cnt, first, busy, exp_cnt, exp_first);
    end
    vec++;
    if (ra !== (exp_cnt != 0 ? 4'b0010 : 4'b0000)) begin
      bad++;
      $display("FAIL stall_notify: got r_abort %b, required %b", ra, exp_cnt != 0 ? 4'b0010 : 4'b0000);
    end
    tick();
    mbox_r_abort = 1'b1;
    tick();
    mbox_r_abort = 1'b0;
    @(negedge aclk);
    vec++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stall_exit: got busy %b, required 0", busy);
    end
  endtask
  task automatic test_reset_mid();
    tick();
    mbox_w_ready      = 1'b0;
    req_w_dat[32 +: 32] = 32'hdead_beef;
    req_w_valid[1]    = 1'b1;
    tick();
    @(negedge aclk);
    vec++;
    if (busy !== 1'b1 || mbox_w_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_grant: got busy %b valid %b, required 1 1", busy, mbox_w_valid);
    end
    #2 resetn = 1'b0;
    #1;
    vec++;
    if (busy !== 1'b0 || mbox_w_valid !== 1'b0 || req_w_ready !== '0 || grant_id !== '0 || mbox_w_dat !== '0) begin
      bad++;
      $display("FAIL reset_mid: got busy %b valid %b ready %b grant %0d dat %h, required all 0", busy, mbox_w_valid, req_w_ready, grant_id, mbox_w_dat);
    end
    req_w_valid  = '0;
    mbox_w_ready = 1'b1;
    tick();
    resetn = 1'b1;
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_two();
    test_wrap();
    test_local_abort();
    test_remote_abort();
    test_collisions();
    test_stall();
    test_reset_mid();
    vec++;
    if (sb.size() != 0 || done_cnt != exp_done) begin
      bad++;
      $display("FAIL scoreboard_end: got %0d beats left %0d dones, required 0 left %0d dones", sb.size(), done_cnt, exp_done);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
